// File: rtl/switch_box_config_loader.sv
// Double-buffered configuration loader for one switch box: streams DW-bit words
// into a shadow register and commits the full vector to c in a single edge.
module switch_box_config_loader #(
  parameter int WS = 8,
  parameter int WD = 8,
  parameter int DW = 8,
  localparam int CB = (WS + WD / 2) * 8,
  localparam int NW = (CB + DW - 1) / DW,
  localparam int CW = $clog2(NW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [CB-1:0] c
);

  typedef enum logic [1:0] {IDLE, LOAD, APPLY} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CB-1:0] shadow_reg, shadow_next;
  logic [CB-1:0] c_reg, c_next;
  logic          done_reg, done_next;
  logic          aborted_reg, aborted_next;
  logic          accept;
  logic          clear_shadow;

  // Once all NW words are in, LOAD lingers one cycle with in_ready low before APPLY.
  assign in_ready = (state_reg == LOAD) && (count_reg < CW'(NW));
  assign accept   = in_ready && in_valid && !abort;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign aborted  = aborted_reg;
  assign c        = c_reg;

  // One slice per word; the last slice is narrower when CB is not a multiple of DW.
  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    localparam int LO = gi * DW;
    localparam int WB = ((CB - LO) < DW) ? (CB - LO) : DW;
    assign shadow_next[LO +: WB] =
        clear_shadow                           ? '0 :
        (accept && (count_reg == CW'(gi)))     ? in_data[WB-1:0] :
                                                 shadow_reg[LO +: WB];
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    c_next       = c_reg;
    done_next    = 1'b0;
    aborted_next = 1'b0;
    clear_shadow = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next   = IDLE;
          count_next   = '0;
          aborted_next = 1'b1;
          clear_shadow = 1'b1;
        end else if (count_reg == CW'(NW)) begin
          state_next = APPLY;
        end else if (accept) begin
          count_next = count_reg + CW'(1);
        end
      end
      APPLY: begin
        state_next = IDLE;
        c_next     = shadow_reg;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      shadow_reg  <= '0;
      c_reg       <= '0;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      shadow_reg  <= shadow_next;
      c_reg       <= c_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
    end
  end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Randomized bench for switch_box_config_loader: DW=8 and DW=7 instances checked
// against a word-list model of the committed configuration.
module tb_switch_box_config_loader;

  localparam int NWA = 12;
  localparam int NWB = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, abort_a, in_valid_a;
  logic [7:0]  in_data_a;
  logic        ready_a, busy_a, done_a, aborted_a;
  logic [95:0] c_a;
  logic        start_b, abort_b, in_valid_b;
  logic [6:0]  in_data_b;
  logic        ready_b, busy_b, done_b, aborted_b;
  logic [95:0] c_b;

  logic [95:0] m_ca, m_cb;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  switch_box_config_loader #(.WS(8), .WD(8), .DW(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(ready_a),
    .busy(busy_a), .done(done_a), .aborted(aborted_a), .c(c_a)
  );

  switch_box_config_loader #(.WS(8), .WD(8), .DW(7)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(ready_b),
    .busy(busy_b), .done(done_b), .aborted(aborted_b), .c(c_b)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word k occupies bits [k*dw +: dw]; anything past bit 95 is dropped.
  function automatic logic [95:0] exp_c(input int w[$], input int dw);
    logic [95:0] r;
    int v;
    r = '0;
    for (int k = 0; k < w.size(); k++) begin
      v = w[k];
      for (int b = 0; b < dw; b++)
        if (k * dw + b < 96) r[k * dw + b] = v[b];
    end
    return r;
  endfunction

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid.
  // pat: <0 random bytes, 256 word index, else constant byte.
  task automatic do_load(input int mode, input int pat, input int abort_at,
                         input bit skip_start, input bit start_mid, input bit chain);
    int w[$];
    int k, cyc, d;
    bit vld, do_abort, ab;
    k = 0; cyc = 0; ab = 0;
    if (!skip_start) begin
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("busy_after_start", busy_a, 1);
    end
    chk("ready_first", ready_a, 1);
    while (k < NWA && !ab) begin
      if (cyc >= 200) begin
        chk("load_timeout", 0, 1);
        break;
      end
      vld = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      d = (pat < 0) ? int'($urandom_range(0, 255)) : (pat == 256) ? k : pat;
      do_abort = (abort_at == k);
      if (do_abort) vld = 1'b1;
      in_valid_a = vld;
      in_data_a  = 8'(d);
      abort_a    = do_abort;
      if (start_mid && k == 3) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; abort_a = 1'b0; in_valid_a = 1'b0;
      if (do_abort) begin
        ab = 1;
        chk("aborted_pulse", aborted_a, 1);
        chk("abort_idle", busy_a, 0);
        chk("abort_c_hold", c_a, m_ca);
        @(posedge clk); #1;
        chk("aborted_clear", aborted_a, 0);
      end else begin
        if (vld) begin
          w.push_back(d);
          k++;
        end
        chk("c_hold_load", c_a, m_ca);
        chk("busy_load", busy_a, 1);
        if (k < NWA) chk("ready_load", ready_a, 1);
      end
      cyc++;
    end
    if (!ab && k == NWA) begin
      chk("ready_after_last", ready_a, 0);
      chk("done_e0", done_a, 0);
      @(posedge clk); #1;
      chk("done_e1", done_a, 0);
      chk("c_hold_e1", c_a, m_ca);
      chk("busy_apply", busy_a, 1);
      @(posedge clk); #1;
      m_ca = exp_c(w, 8);
      chk("done_e2", done_a, 1);
      chk("c_commit", c_a, m_ca);
      chk("busy_after_done", busy_a, 0);
      if (chain) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("done_one_cycle", done_a, 0);
      chk("busy_chain", busy_a, chain);
      chk("c_stable_after", c_a, m_ca);
    end
    $display("[TB] load mode=%0d words=%0d aborted=%0d c=%h", mode, k, ab, c_a);
  endtask

  task automatic do_load_b(input int pat);
    int w[$];
    int d;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 0; k < NWB; k++) begin
      chk("b_ready", ready_b, 1);
      d = (pat < 0) ? int'($urandom_range(0, 127)) : pat;
      in_valid_b = 1'b1;
      in_data_b  = 7'(d);
      w.push_back(d);
      @(posedge clk); #1;
      chk("b_c_hold", c_b, m_cb);
    end
    in_valid_b = 1'b0;
    chk("b_ready_end", ready_b, 0);
    @(posedge clk); #1;
    chk("b_done_early", done_b, 0);
    @(posedge clk); #1;
    m_cb = exp_c(w, 7);
    chk("b_done", done_b, 1);
    chk("b_c", c_b, m_cb);
    $display("[TB] dw7 load words=%0d c=%h", NWB, c_b);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_a = 0; abort_a = 0; in_valid_a = 0; in_data_a = '0;
    start_b = 0; abort_b = 0; in_valid_b = 0; in_data_b = '0;
    m_ca = '0; m_cb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_c", c_a, 0);
    chk("rst_ready", ready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_aborted", aborted_a, 0);
    rst = 1'b0;

    // Valid words offered while idle are not taken.
    in_valid_a = 1'b1; in_data_a = 8'h5A;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ready", ready_a, 0);
      chk("idle_busy", busy_a, 0);
    end
    in_valid_a = 1'b0;
    $display("[TB] idle valid ignored c=%h", c_a);

    do_load(0, 256, -1, 0, 0, 0);
    do_load(1, 255, -1, 0, 0, 0);
    do_load(0, 255, -1, 0, 0, 0);
    do_load(0, 255, 5, 0, 0, 0);
    do_load(0, 8'hA5, -1, 0, 0, 0);

    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("idle_abort_ignored", aborted_a, 0);
    chk("idle_abort_busy", busy_a, 0);
    $display("[TB] abort in idle");

    start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    chk("start_abort_busy", busy_a, 1);
    chk("start_abort_no_pulse", aborted_a, 0);
    do_load(0, -1, -1, 1, 0, 0);

    do_load(2, -1, -1, 0, 1, 0);
    do_load(0, -1, -1, 0, 0, 1);
    do_load(1, -1, -1, 1, 0, 0);

    // Reset after six words discards the load and clears c.
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid_a = 1'b1; in_data_a = 8'(k + 1);
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ca = '0;
    chk("midrst_c", c_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ready", ready_a, 0);
    $display("[TB] reset mid-load c=%h", c_a);
    do_load(0, -1, -1, 0, 1, 0);

    for (int i = 0; i < 8; i++)
      do_load(int'($urandom_range(0, 2)), -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NWA - 1)) : -1,
              0, 0, 0);

    chk("b_reset_c", c_b, 0);
    do_load_b(8'h7F);
    do_load_b(-1);
    do_load_b(-1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
